vpu_seq_ctrl: RTL and testbench
===============================

// Module: vpu_seq_ctrl
// PURPOSE
//  Command-driven sequencer for the vector ALU (vpu_op). Accepts one vector command
//  (opcode, two source base addresses, destination base, length) and streams elements
//  from a dual-read-port scratchpad through the VPU datapath. Writes one result per cycle
//  back to the scratchpad. Sits between the top-level instruction decoder and the
//  vpu_op instance plus the vector scratchpad.
// PARAMETERS
//  DATA_W  32  element width (fp32)
//  OP_W    10  opcode width, passed unchanged to vpu_op
//  ADDR_W  10  scratchpad word-address width
//  LEN_W   11  element-count width (max len = 2**LEN_W-1)
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous reset, active-high
//  cmd_valid     in   1       command valid
//  cmd_ready     out  1       command accepted when valid&&ready
//  cmd_opcode    in   OP_W    VPU opcode: 0 ADD, 1 SUB, 2 RELU, 3 MUL, 4 D_RELU
//  cmd_src0      in   ADDR_W  operand0 base address
//  cmd_src1      in   ADDR_W  operand1 base address
//  cmd_dst       in   ADDR_W  result base address
//  cmd_len       in   LEN_W   element count
//  rd_en         out  1       scratchpad read strobe (both ports)
//  rd_addr0      out  ADDR_W  port-0 read address
//  rd_addr1      out  ADDR_W  port-1 read address
//  rd_data0      in   DATA_W  port-0 data, valid 1 cycle after rd_en
//  rd_data1      in   DATA_W  port-1 data, valid 1 cycle after rd_en
//  vpu_start     out  1       high while vpu operands are valid
//  vpu_opcode    out  OP_W    latched command opcode
//  vpu_operand0  out  DATA_W  = rd_data0 (combinational)
//  vpu_operand1  out  DATA_W  = rd_data1 (combinational)
//  vpu_result    in   DATA_W  vpu_op result_out (combinational)
//  wr_en         out  1       scratchpad write strobe
//  wr_addr       out  ADDR_W  write address
//  wr_data       out  DATA_W  write data (registered vpu_result)
//  busy          out  1       command in progress (state != IDLE)
//  done          out  1       one-cycle pulse after the final write
// BEHAVIOUR
//  - Reset: state=IDLE; all counters, pipeline valids, rd_en, wr_en, vpu_start, done
//    and busy = 0; addresses, opcode and wr_data = 0; cmd_ready=1.
//  - FSM IDLE -> RUN on accept with len>0; IDLE -> IDLE (done pulse next cycle) on len=0.
//    RUN -> DRAIN after the last read issue. DRAIN -> IDLE once the pipeline is empty.
//  - cmd_ready = (state==IDLE). All cmd_* fields are latched on accept. Inputs are
//    ignored while busy.
//  - Accept at edge T. Element k: rd_en at cycle T+1+k (addr0=src0+k, addr1=src1+k).
//    vpu_start at T+2+k. wr_en at T+3+k with wr_addr=dst+k and wr_data = vpu_result
//    registered at T+2+k.
//  - Throughput is 1 element/cycle with no bubbles. Last write at T+2+len. done=1 and
//    busy=0 at T+3+len, and a new command may be accepted in that cycle.
//  - len=0: accept at T, done=1 at T+1, no rd_en/wr_en/vpu_start.
//  - Address arithmetic is modulo 2**ADDR_W. Wrap past the top is legal and silent.
//  - Unknown opcodes are forwarded. vpu_op returns 0, so zeros are written.
//    Length and timing are unchanged.
//  - No read/write hazard forwarding. In-place (dst==src) is safe because element k is
//    read before it is written. Other overlaps are the issuer's responsibility.
//  - rst mid-command aborts immediately. No further rd_en/wr_en, no done pulse, and the
//    FSM returns to IDLE.
// TESTING
//  1. ADD len=4, src0=0:{1.0,2.0,-1.0,0}, src1=16:{2.0,1.0,1.0,0}, dst=32 ->
//     wr 32..35 = 40400000,40400000,00000000,00000000 at T+3..T+6; done at T+7.
//  2. RELU len=2, src0={bf800000,40000000} -> wr {00000000,40000000}.
//     D_RELU on the same data -> {00000000,3f800000}.
//  3. len=0 command -> done exactly 1 cycle after accept; zero rd_en/wr_en pulses.
//  4. Second cmd_valid held high during a len=8 command -> cmd_ready low until the done
//     cycle, then accepted in that cycle; no gap/overlap in writes.
//  5. src0=1022, dst=1023, len=4 (ADDR_W=10) -> reads 1022,1023,0,1;
//     writes 1023,0,1,2.
//  6. rst asserted at T+3 of a len=8 MUL -> all outputs zero next cycle, no done pulse,
//     cmd_ready=1 after release.

Source files
------------

// File: rtl/vpu_seq_ctrl.sv
// vpu_seq_ctrl: command-driven sequencer for the vector ALU.
// One accepted command streams len elements through a three-stage pipeline:
// read issue -> operands valid at the VPU -> registered result written back.
// One element per cycle, no bubbles; done pulses the cycle after the last write.
module vpu_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 10,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_opcode,
    input  logic [ADDR_W-1:0] cmd_src0,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    input  logic [DATA_W-1:0] rd_data0,
    input  logic [DATA_W-1:0] rd_data1,
    output logic              vpu_start,
    output logic [OP_W-1:0]   vpu_opcode,
    output logic [DATA_W-1:0] vpu_operand0,
    output logic [DATA_W-1:0] vpu_operand1,
    input  logic [DATA_W-1:0] vpu_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [OP_W-1:0]   opcode_q,    opcode_d;
    logic              rd_en_q,     rd_en_d;
    logic [ADDR_W-1:0] rd_addr0_q,  rd_addr0_d;
    logic [ADDR_W-1:0] rd_addr1_q,  rd_addr1_d;
    // Reads still to issue after the one currently on rd_en.
    logic [LEN_W-1:0]  remain_q,    remain_d;
    // Destination address of the element whose operands are at the VPU.
    logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic              vpu_start_q, vpu_start_d;
    logic              wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,   wr_data_d;
    logic              done_q,      done_d;

    // Next-state, read-issue and pipeline-advance logic.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        rd_en_d     = 1'b0;
        rd_addr0_d  = rd_addr0_q;
        rd_addr1_d  = rd_addr1_q;
        remain_d    = remain_q;
        wr_ptr_d    = wr_ptr_q;
        vpu_start_d = rd_en_q;
        wr_en_d     = vpu_start_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;

        // Capture the VPU result while its operands are valid; the write
        // goes out the following cycle.
        if (vpu_start_q) begin
            wr_addr_d = wr_ptr_q;
            wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
            wr_data_d = vpu_result;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    opcode_d = cmd_opcode;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = RUN;
                        rd_en_d    = 1'b1;
                        rd_addr0_d = cmd_src0;
                        rd_addr1_d = cmd_src1;
                        remain_d   = cmd_len - LEN_W'(1);
                        wr_ptr_d   = cmd_dst;
                    end
                end
            end
            RUN: begin
                if (remain_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    rd_en_d    = 1'b1;
                    rd_addr0_d = rd_addr0_q + ADDR_W'(1);
                    rd_addr1_d = rd_addr1_q + ADDR_W'(1);
                    remain_d   = remain_q - LEN_W'(1);
                end
            end
            DRAIN: begin
                // Only the final write is left in flight once vpu_start drops.
                if (!vpu_start_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and pipeline registers; reset aborts any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q    <= '0;
            rd_en_q     <= 1'b0;
            rd_addr0_q  <= '0;
            rd_addr1_q  <= '0;
            remain_q    <= '0;
            wr_ptr_q    <= '0;
            vpu_start_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            opcode_q    <= opcode_d;
            rd_en_q     <= rd_en_d;
            rd_addr0_q  <= rd_addr0_d;
            rd_addr1_q  <= rd_addr1_d;
            remain_q    <= remain_d;
            wr_ptr_q    <= wr_ptr_d;
            vpu_start_q <= vpu_start_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign rd_en        = rd_en_q;
    assign rd_addr0     = rd_addr0_q;
    assign rd_addr1     = rd_addr1_q;
    assign vpu_start    = vpu_start_q;
    assign vpu_opcode   = opcode_q;
    assign vpu_operand0 = rd_data0;
    assign vpu_operand1 = rd_data1;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign done         = done_q;

endmodule

// File: tb/tb_vpu_seq_ctrl.sv
// Self-checking bench for vpu_seq_ctrl: scratchpad and vpu_op stand-ins,
// a per-command reference model that predicts every read, write and done
// cycle, directed cases followed by randomized commands.
module tb_vpu_seq_ctrl;

    localparam int DW = 32;
    localparam int OW = 10;
    localparam int AW = 10;
    localparam int LW = 11;
    localparam int MEM_WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [OW-1:0] cmd_opcode;
    logic [AW-1:0] cmd_src0, cmd_src1, cmd_dst;
    logic [LW-1:0] cmd_len;
    logic          rd_en;
    logic [AW-1:0] rd_addr0, rd_addr1;
    logic [DW-1:0] rd_data0 = '0;
    logic [DW-1:0] rd_data1 = '0;
    logic          vpu_start;
    logic [OW-1:0] vpu_opcode;
    logic [DW-1:0] vpu_operand0, vpu_operand1, vpu_result;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy, done;

    always #5 clk = ~clk;

    vpu_seq_ctrl #(.DATA_W(DW), .OP_W(OW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .vpu_start(vpu_start), .vpu_opcode(vpu_opcode),
        .vpu_operand0(vpu_operand0), .vpu_operand1(vpu_operand1), .vpu_result(vpu_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    // ---------------- fp32 helpers and vpu_op stand-in ----------------
    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] vpu_fn(input logic [OW-1:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
        case (op)
            10'd0:   return r2f(f2r(a) + f2r(b));
            10'd1:   return r2f(f2r(a) - f2r(b));
            10'd2:   return a[31] ? 32'h0 : a;
            10'd3:   return r2f(f2r(a) * f2r(b));
            10'd4:   return (!a[31] && a[30:0] != 31'd0) ? 32'h3f800000 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    assign vpu_result = vpu_fn(vpu_opcode, vpu_operand0, vpu_operand1);

    // ---------------- scratchpad model (read latency 1) ----------------
    logic [DW-1:0] mem     [MEM_WORDS];
    logic [DW-1:0] ref_mem [MEM_WORDS];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data0 <= mem[rd_addr0];
            rd_data1 <= mem[rd_addr1];
        end
        if (wr_en) mem[wr_addr] = wr_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          at;
        int          a0;
        int          a1;
        logic [31:0] d;
    } ev_t;

    ev_t rdq[$];
    ev_t wrq[$];
    int  doneq[$];
    int  acc_log[$];
    int  busy_lo = 0, busy_hi = -1;
    int  vs_lo = 0, vs_hi = -1;
    logic [OW-1:0] cur_op = '0;

    // Predict every event of a command accepted at the end of cycle t.
    task automatic model_accept(input int t);
        int          len;
        logic [31:0] res[$];
        len = int'(cmd_len);
        cur_op = cmd_opcode;
        acc_log.push_back(t);
        $display("cmd t=%0d op=%0d src0=%0d src1=%0d dst=%0d len=%0d",
                 t, cmd_opcode, cmd_src0, cmd_src1, cmd_dst, len);
        if (len == 0) begin
            doneq.push_back(t + 1);
            return;
        end
        for (int k = 0; k < len; k++) begin
            int a0, a1;
            a0 = (int'(cmd_src0) + k) % MEM_WORDS;
            a1 = (int'(cmd_src1) + k) % MEM_WORDS;
            rdq.push_back('{t + 1 + k, a0, a1, 32'h0});
            res.push_back(vpu_fn(cmd_opcode, ref_mem[a0], ref_mem[a1]));
        end
        for (int k = 0; k < len; k++) begin
            int ad;
            ad = (int'(cmd_dst) + k) % MEM_WORDS;
            wrq.push_back('{t + 3 + k, ad, 0, res[k]});
            ref_mem[ad] = res[k];
        end
        doneq.push_back(t + 3 + len);
        busy_lo = t + 1;
        busy_hi = t + 2 + len;
        vs_lo   = t + 2;
        vs_hi   = t + 1 + len;
    endtask

    // Per-cycle monitor: compare observed activity against the predictions.
    always @(negedge clk) begin
        if (rst) begin
            rdq.delete();
            wrq.delete();
            doneq.delete();
            busy_hi = -1;
            vs_hi   = -1;
        end else begin
            logic exp_busy, exp_vs;
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            exp_vs   = (cyc >= vs_lo) && (cyc <= vs_hi);
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("cmd_ready", 64'(cmd_ready), 64'(!exp_busy));
            chk("vpu_start", 64'(vpu_start), 64'(exp_vs));
            if (vpu_start) chk("vpu_opcode", 64'(vpu_opcode), 64'(cur_op));

            if (rdq.size() > 0 && rdq[0].at < cyc) begin
                chk("rd_missing", 64'(cyc), 64'(rdq[0].at));
                void'(rdq.pop_front());
            end
            if (rd_en) begin
                if (rdq.size() == 0) chk("rd_spurious", 64'(1), 64'(0));
                else begin
                    ev_t e;
                    e = rdq.pop_front();
                    chk("rd_cyc", 64'(cyc), 64'(e.at));
                    chk("rd_addr0", 64'(rd_addr0), 64'(e.a0));
                    chk("rd_addr1", 64'(rd_addr1), 64'(e.a1));
                end
            end

            if (wrq.size() > 0 && wrq[0].at < cyc) begin
                chk("wr_missing", 64'(cyc), 64'(wrq[0].at));
                void'(wrq.pop_front());
            end
            if (wr_en) begin
                if (wrq.size() == 0) chk("wr_spurious", 64'(1), 64'(0));
                else begin
                    ev_t e;
                    e = wrq.pop_front();
                    chk("wr_cyc", 64'(cyc), 64'(e.at));
                    chk("wr_addr", 64'(wr_addr), 64'(e.a0));
                    chk("wr_data", 64'(wr_data), 64'(e.d));
                end
            end

            if (doneq.size() > 0 && doneq[0] < cyc) begin
                chk("done_missing", 64'(cyc), 64'(doneq[0]));
                void'(doneq.pop_front());
            end
            if (done) begin
                if (doneq.size() == 0) chk("done_spurious", 64'(1), 64'(0));
                else chk("done_cyc", 64'(cyc), 64'(doneq.pop_front()));
            end

            if (cmd_valid && cmd_ready) model_accept(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic poke(input int a, input logic [31:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic issue(input logic [OW-1:0] op, input logic [AW-1:0] s0,
                         input logic [AW-1:0] s1, input logic [AW-1:0] d,
                         input logic [LW-1:0] len);
        int n;
        cmd_opcode = op;
        cmd_src0   = s0;
        cmd_src1   = s1;
        cmd_dst    = d;
        cmd_len    = len;
        cmd_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready) begin
            n++;
            if (n > 3000) begin
                chk("accept_timeout", 64'(0), 64'(1));
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && wrq.size() == 0 && rdq.size() == 0 && doneq.size() == 0) return;
        end
        chk("idle_timeout", 64'(0), 64'(1));
    endtask

    task automatic check_reset_outputs();
        chk("rst_rd_en", 64'(rd_en), 64'(0));
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_vpu_start", 64'(vpu_start), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_rd_addr0", 64'(rd_addr0), 64'(0));
        chk("rst_rd_addr1", 64'(rd_addr1), 64'(0));
        chk("rst_wr_addr", 64'(wr_addr), 64'(0));
        chk("rst_wr_data", 64'(wr_data), 64'(0));
        chk("rst_vpu_opcode", 64'(vpu_opcode), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        int t1;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_src0   = '0;
        cmd_src1   = '0;
        cmd_dst    = '0;
        cmd_len    = '0;
        for (int i = 0; i < MEM_WORDS; i++)
            poke(i, r2f(real'(int'($urandom_range(16)) - 8)));

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;

        // 1. ADD, len 4
        poke(0, 32'h3f800000); poke(1, 32'h40000000); poke(2, 32'hbf800000); poke(3, 32'h0);
        poke(16, 32'h40000000); poke(17, 32'h3f800000); poke(18, 32'h3f800000); poke(19, 32'h0);
        issue(10'd0, 10'd0, 10'd16, 10'd32, 11'd4);
        wait_idle();
        chk("add_res0", 64'(mem[32]), 64'h40400000);
        chk("add_res1", 64'(mem[33]), 64'h40400000);
        chk("add_res2", 64'(mem[34]), 64'h0);
        chk("add_res3", 64'(mem[35]), 64'h0);

        // 2. RELU and D_RELU on the same data
        poke(40, 32'hbf800000); poke(41, 32'h40000000);
        issue(10'd2, 10'd40, 10'd300, 10'd50, 11'd2);
        wait_idle();
        issue(10'd4, 10'd40, 10'd300, 10'd60, 11'd2);
        wait_idle();
        chk("relu0", 64'(mem[50]), 64'h0);
        chk("relu1", 64'(mem[51]), 64'h40000000);
        chk("drelu0", 64'(mem[60]), 64'h0);
        chk("drelu1", 64'(mem[61]), 64'h3f800000);

        // 3. zero-length command
        issue(10'd0, 10'd5, 10'd300, 10'd520, 11'd0);
        wait_idle();

        // 4. back-to-back with cmd_valid held high
        issue(10'd3, 10'd8, 10'd264, 10'd530, 11'd8);
        t1 = acc_log[acc_log.size() - 1];
        issue(10'd1, 10'd20, 10'd280, 10'd560, 11'd5);
        chk("b2b_accept_cyc", 64'(acc_log[acc_log.size() - 1]), 64'(t1 + 11));
        wait_idle();

        // 5. address wrap at the top of the scratchpad
        issue(10'd0, 10'd1022, 10'd300, 10'd1023, 11'd4);
        wait_idle();

        // 6. reset during a MUL
        issue(10'd3, 10'd100, 10'd400, 10'd900, 11'd8);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", 64'(cmd_ready), 64'(1));
        repeat (12) @(negedge clk);

        // randomized commands, in-place some of the time
        for (int n = 0; n < 24; n++) begin
            logic [AW-1:0] s0, s1, d;
            logic [LW-1:0] len;
            logic [OW-1:0] op;
            op  = OW'($urandom_range(5));
            len = (n % 6 == 5) ? LW'(1) : LW'($urandom_range(40));
            s0  = AW'($urandom_range(200));
            s1  = AW'(256 + $urandom_range(200));
            d   = ($urandom_range(3) == 0) ? s0 : AW'(512 + $urandom_range(200));
            issue(op, s0, s1, d, len);
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end
        wait_idle();
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
